// File: rtl/sipo_pkg.sv
// ============================================================================
//  Module : sipo_pkg
//  Brief  : Shared types and constants for the SIPO serial receiver.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : sipo_pkg

`default_nettype wire

// File: rtl/sipo_hold_reg.sv
// ============================================================================
//  Module : sipo_hold_reg
//  Brief  : Output holding register with valid/ready handshake and sticky
//           overrun flag for words that arrive while the slot is blocked.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             w_ovr_set;

  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    w_ovr_set = 1'b0;
    if (load_i) begin
      // The slot is free if empty or being drained this very cycle.
      if (!valid_q || ready_i) begin
        dout_d  = word_i;
        valid_d = 1'b1;
      end else begin
        w_ovr_set = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    overrun_d = w_ovr_set | (overrun_q & ~ovr_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout_o    = dout_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : sipo_hold_reg

`default_nettype wire

// File: rtl/sipo_shift_reg_rx.sv
// ============================================================================
//  Module : sipo_shift_reg_rx
//  Brief  : Serial-in parallel-out deserializer: sync-framed bit capture into
//           a WIDTH-bit word, presented through a valid/ready holding register.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CE,
  input  logic             sin,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_shifted;
  logic             w_complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {sr_q[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_shifted = {sin, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    w_complete = 1'b0;
    if (CE) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            sr_d    = w_shifted;
            cnt_d   = CNT_ONE;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sr_d = w_shifted;
          // A sync mid-frame restarts the frame; the partial word is abandoned.
          if (sync) begin
            cnt_d = CNT_ONE;
          end else if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            w_complete = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_complete),
    .word_i    (w_shifted),
    .ready_i   (dout_ready),
    .ovr_clr_i (ovr_clr),
    .dout_o    (dout),
    .valid_o   (dout_valid),
    .overrun_o (overrun)
  );

endmodule : sipo_shift_reg_rx

`default_nettype wire

// File: tb/tb_sipo_shift_reg_rx.sv
// ============================================================================
//  Module : tb_sipo_shift_reg_rx
//  Brief  : Directed self-checking bench for sipo_shift_reg_rx (LSB-first,
//           MSB-first and WIDTH=2 instances driven by the same serial line).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sipo_shift_reg_rx;

  logic       clk = 1'b0;
  logic       rst_n, CE, sin, sync, dout_ready, ovr_clr;
  logic [3:0] dout0, dout1;
  logic [1:0] dout2;
  logic       valid0, valid1, valid2;
  logic       busy0, busy1, busy2;
  logic       ovr0, ovr1, ovr2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_shift_reg_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .CE(CE), .sin(sin), .sync(sync),
    .dout(dout0), .dout_valid(valid0), .dout_ready(dout_ready),
    .busy(busy0), .overrun(ovr0), .ovr_clr(ovr_clr)
  );

  sipo_shift_reg_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .CE(CE), .sin(sin), .sync(sync),
    .dout(dout1), .dout_valid(valid1), .dout_ready(dout_ready),
    .busy(busy1), .overrun(ovr1), .ovr_clr(ovr_clr)
  );

  sipo_shift_reg_rx #(.WIDTH(2), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .CE(CE), .sin(sin), .sync(sync),
    .dout(dout2), .dout_valid(valid2), .dout_ready(dout_ready),
    .busy(busy2), .overrun(ovr2), .ovr_clr(ovr_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic b);
    CE   = 1'b1;
    sync = s;
    sin  = b;
    tick();
    CE   = 1'b0;
    sync = 1'b0;
    sin  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; CE = 1'b0; sin = 1'b0; sync = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    #2;
    check("reset_dout",    32'(dout0),  32'h0);
    check("reset_valid",   32'(valid0), 32'h0);
    check("reset_busy",    32'(busy0),  32'h0);
    check("reset_overrun", 32'(ovr0),   32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: back-to-back bits 0,1,0,1 -> 4'hA, valid for exactly one cycle
    dout_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    check("t1_busy_bit0", 32'(busy0), 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check("t1_valid_early", 32'(valid0), 32'h0);
    send_bit(1'b0, 1'b1);
    check("t1_valid", 32'(valid0), 32'h1);
    check("t1_dout",  32'(dout0),  32'hA);
    check("t1_busy_done", 32'(busy0), 32'h0);
    tick();
    check("t1_valid_drop", 32'(valid0), 32'h0);
    check("t1_dout_hold",  32'(dout0),  32'hA);

    // 2: CE every 3rd clock; a sync with CE=0 in a gap must be ignored
    send_bit(1'b1, 1'b0);
    sync = 1'b1; sin = 1'b1;
    tick();
    sync = 1'b0; sin = 1'b0;
    check("t2_busy_gap", 32'(busy0), 32'h1);
    tick();
    send_bit(1'b0, 1'b1);
    tick(); tick();
    send_bit(1'b0, 1'b0);
    tick();
    check("t2_busy_gap2", 32'(busy0), 32'h1);
    tick();
    send_bit(1'b0, 1'b1);
    check("t2_valid", 32'(valid0), 32'h1);
    check("t2_dout",  32'(dout0),  32'hA);
    check("t2_busy_done", 32'(busy0), 32'h0);
    tick();

    // 3: mid-frame sync restarts the frame without overrun
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check("t3_busy_restart", 32'(busy0), 32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t3_valid_early", 32'(valid0), 32'h0);
    send_bit(1'b0, 1'b0);
    check("t3_valid",   32'(valid0), 32'h1);
    check("t3_dout",    32'(dout0),  32'h1);
    check("t3_overrun", 32'(ovr0),   32'h0);
    tick();

    // 4: blocked consumer -> second word dropped, overrun set
    dout_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    check("t4_first_dout", 32'(dout0), 32'h3);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    check("t4_hold_dout", 32'(dout0),  32'h3);
    check("t4_hold_valid", 32'(valid0), 32'h1);
    check("t4_overrun",   32'(ovr0),   32'h1);
    dout_ready = 1'b1;
    tick();
    check("t4_xfer_valid", 32'(valid0), 32'h0);
    check("t4_xfer_dout",  32'(dout0),  32'h3);
    check("t4_ovr_sticky", 32'(ovr0),   32'h1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t4_ovr_clr", 32'(ovr0), 32'h0);
    // set wins over a simultaneous clear
    dout_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    check("t4_load5", 32'(dout0), 32'h5);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    ovr_clr = 1'b1;
    send_bit(1'b0, 1'b1);
    ovr_clr = 1'b0;
    check("t4_set_wins", 32'(ovr0),  32'h1);
    check("t4_keep5",    32'(dout0), 32'h5);

    // 5: async reset mid-frame with a word pending
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("t5_busy_pre", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout",    32'(dout0),  32'h0);
    check("t5_rst_valid",   32'(valid0), 32'h0);
    check("t5_rst_busy",    32'(busy0),  32'h0);
    check("t5_rst_overrun", 32'(ovr0),   32'h0);
    tick();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
    check("t5_valid", 32'(valid0), 32'h1);
    check("t5_dout",  32'(dout0),  32'h5);
    tick();

    // 6: bit order; bits 1,0,1,1
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    check("t6_msb_dout",  32'(dout1),  32'hB);
    check("t6_msb_valid", 32'(valid1), 32'h1);
    check("t6_lsb_dout",  32'(dout0),  32'hD);
    tick();
    // CE without sync while idle
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("t6_idle_busy0",  32'(busy0),  32'h0);
    check("t6_idle_busy1",  32'(busy1),  32'h0);
    check("t6_idle_busy2",  32'(busy2),  32'h0);
    check("t6_idle_valid0", 32'(valid0), 32'h0);

    // WIDTH=2: sync bit then one more bit completes the word
    send_bit(1'b1, 1'b0);
    check("w2_busy", 32'(busy2), 32'h1);
    send_bit(1'b0, 1'b1);
    check("w2_valid", 32'(valid2), 32'h1);
    check("w2_dout",  32'(dout2),  32'h2);
    check("w2_busy_done", 32'(busy2), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sipo_shift_reg_rx

`default_nettype wire
